// File: rtl/mcp3_arb03_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcp3_arb_pkg
// Brief    : Shared state encoding and constants for the 3-way arbiter.
// Revision : 1.0
// ============================================================================
package mcp3_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_t;

   localparam logic [2:0] RR_PTR_RST = 3'b100;
   localparam logic [2:0] GNT_NONE   = 3'b000;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcp3_arb03_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : mcp3_arb03_ctl_if
// Brief    : Request/grant/status bundle of the 3-way arbiter, plus a
//            pointer-write hook used to exercise the one-hot self-check.
// Revision : 1.0
// ============================================================================
interface mcp3_arb03_ctl_if;
   logic [2:0] req;
   logic [2:0] done;
   logic       err_clear;
   logic [2:0] grant;
   logic       grant_valid;
   logic [2:0] last_winner;
   logic       oh_err;
   logic       timeout_err;
   logic       dbg_ptr_we;
   logic [2:0] dbg_ptr_val;

   modport master (
      output req, done, err_clear, dbg_ptr_we, dbg_ptr_val,
      input  grant, grant_valid, last_winner, oh_err, timeout_err
   );

   modport slave (
      input  req, done, err_clear, dbg_ptr_we, dbg_ptr_val,
      output grant, grant_valid, last_winner, oh_err, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/mcp3_arb03_ctl_ohchk.sv
`default_nettype none
// ============================================================================
// Module   : mcp3_oh3_chk
// Brief    : 3-bit one-hot checker; flags a non-one-hot vector when enabled.
// Revision : 1.0
// ============================================================================
module mcp3_oh3_chk
   import mcp3_arb_pkg::*;
(
   input  wire logic [2:0] vec,
   input  wire logic       en,
   output logic            err
);

   assign err = en && !is_onehot3(vec);

endmodule
`default_nettype wire

// File: rtl/mcp3_arb03_ctl_pick.sv
`default_nettype none
// ============================================================================
// Module   : mcp3_rr03_pick
// Brief    : Combinational round-robin pick over three requesters.
// Revision : 1.0
// ============================================================================
module mcp3_rr03_pick
   import mcp3_arb_pkg::*;
(
   input  wire logic [2:0] req,
   input  wire logic [2:0] pointer,
   input  wire logic [2:0] exclude,
   output logic      [2:0] winner,
   output logic            any
);

   logic [2:0] w_cand;
   logic [1:0] w_base;
   logic [2:0] w_rot;
   logic [2:0] w_low;

   always_comb begin
      w_cand = req & ~exclude;
      any    = |w_cand;
      // Scan starts just above the pointer; a malformed pointer restarts at bit 0.
      if (pointer[0])      w_base = 2'd1;
      else if (pointer[1]) w_base = 2'd2;
      else                 w_base = 2'd0;

      case (w_base)
         2'd1:    w_rot = {w_cand[0], w_cand[2:1]};
         2'd2:    w_rot = {w_cand[1:0], w_cand[2]};
         default: w_rot = w_cand;
      endcase

      w_low = w_rot & (~w_rot + 3'd1);

      case (w_base)
         2'd1:    winner = {w_low[1:0], w_low[2]};
         2'd2:    winner = {w_low[0], w_low[2:1]};
         default: winner = w_low;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mcp3_arb03_ctl.sv
`default_nettype none
// ============================================================================
// Module   : mcp3_arb03_ctl
// Brief    : Three-requester round-robin arbiter with held grant, one-hot
//            self-check and optional watchdog (MCP3_ARB03_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
module mcp3_arb03_ctl
   import mcp3_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMR_WIDTH      = 16
) (
   input  wire logic        clock,
   input  wire logic        reset,
   mcp3_arb03_ctl_if.slave  bus
);

   arb_state_t state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [2:0] last_winner_q, last_winner_d;
   logic       grant_valid_q, grant_valid_d;
   logic       oh_err_q, oh_err_d;
   logic [2:0] w_winner;
   logic [2:0] w_exclude;
   logic       w_any;
   logic       w_done_owner;
   logic       w_expire;
   logic       w_release;
   logic       w_ptr_bad;
   logic       w_gnt_bad;

   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > ((1 << TMR_WIDTH) - 1))) begin : g_cfg_bad
      $error("mcp3_arb03_ctl: TIMEOUT_CYCLES does not fit TMR_WIDTH or is below 2");
   end

   assign w_exclude    = (state_q == ST_OWNED) ? grant_q : GNT_NONE;
   assign w_done_owner = (state_q == ST_OWNED) && (|(bus.done & grant_q));
   assign w_release    = (state_q == ST_OWNED) && (w_done_owner || w_expire);

   mcp3_rr03_pick u_pick (
      .req     (bus.req),
      .pointer (last_winner_q),
      .exclude (w_exclude),
      .winner  (w_winner),
      .any     (w_any)
   );

   mcp3_oh3_chk u_chk_ptr (
      .vec (last_winner_q),
      .en  (1'b1),
      .err (w_ptr_bad)
   );

   mcp3_oh3_chk u_chk_gnt (
      .vec (grant_q),
      .en  (grant_valid_q),
      .err (w_gnt_bad)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_winner_d = last_winner_q;
      case (state_q)
         ST_IDLE: begin
            if (w_any) begin
               grant_d       = w_winner;
               last_winner_d = w_winner;
               state_d       = ST_OWNED;
            end
         end
         ST_OWNED: begin
            if (w_release) begin
               if (w_any) begin
                  grant_d       = w_winner;
                  last_winner_d = w_winner;
               end else if (w_done_owner && (|(bus.req & grant_q))) begin
                  // Sole requester releasing while still requesting keeps the slot.
                  grant_d = grant_q;
               end else begin
                  grant_d = GNT_NONE;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            grant_d = GNT_NONE;
            state_d = ST_IDLE;
         end
      endcase
      if (bus.dbg_ptr_we) begin
         last_winner_d = bus.dbg_ptr_val;
      end
      grant_valid_d = |grant_d;
      oh_err_d      = w_ptr_bad || w_gnt_bad || (oh_err_q && !bus.err_clear);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         grant_q       <= GNT_NONE;
         grant_valid_q <= 1'b0;
         last_winner_q <= RR_PTR_RST;
         oh_err_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         last_winner_q <= last_winner_d;
         oh_err_q      <= oh_err_d;
      end
   end

`ifdef MCP3_ARB03_TIMEOUT_EN
   logic [TMR_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
   logic                 timeout_err_q, timeout_err_d;

   // A done in the expiry cycle wins, so the watchdog never fires alongside it.
   assign w_expire = (state_q == ST_OWNED) && !w_done_owner &&
                     (hold_cnt_q == TMR_WIDTH'(TIMEOUT_CYCLES - 1));

   always_comb begin
      hold_cnt_d = '0;
      if ((state_q == ST_OWNED) && !w_release) begin
         hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + TMR_WIDTH'(1);
      end
      timeout_err_d = w_expire || (timeout_err_q && !bus.err_clear);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         hold_cnt_q    <= hold_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   assign w_expire        = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.grant       = grant_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.last_winner = last_winner_q;
   assign bus.oh_err      = oh_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp3_arb03_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcp3_arb03_ctl
// Brief    : Self-checking bench for mcp3_arb03_ctl: vector table, corner
//            sequences and random traffic against an index-based model.
// Revision : 1.0
// ============================================================================
module tb_mcp3_arb03_ctl;

   localparam int TMO = 4;
`ifdef MCP3_ARB03_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mcp3_arb03_ctl_if bus ();

   mcp3_arb03_ctl #(
      .TIMEOUT_CYCLES (TMO),
      .TMR_WIDTH      (16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner / pointer as requester indices, -1 = no owner.
   int m_owner;
   int m_ptr;
   int m_cnt;
   bit m_to_err;

   typedef struct {
      logic [2:0] req;
      logic [2:0] done;
      logic [2:0] exp_grant;
      logic [2:0] exp_lw;
   } vec_t;
   vec_t vecs [16];

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int rr_search(input logic [2:0] cand, input int ptr);
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (ptr + k) % 3;
         if (cand[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_ptr    = 2;
      m_cnt    = 0;
      m_to_err = 1'b0;
   endtask

   task automatic model_cycle(input logic [2:0] req, input logic [2:0] done, input logic clr);
      bit         rel;
      bit         expire;
      int         w;
      logic [2:0] others;
      expire = 1'b0;
      if (m_owner < 0) begin
         w = rr_search(req, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_ptr   = w;
            m_cnt   = 0;
         end
      end else begin
         rel    = done[m_owner];
         expire = WD_EN && !rel && (m_cnt == TMO - 1);
         if (rel || expire) begin
            others          = req;
            others[m_owner] = 1'b0;
            w = rr_search(others, m_ptr);
            if (w >= 0) begin
               m_owner = w;
               m_ptr   = w;
            end else if (!(rel && req[m_owner])) begin
               m_owner = -1;
            end
            m_cnt = 0;
         end else if (m_cnt < 65535) begin
            m_cnt++;
         end
      end
      if (expire)   m_to_err = 1'b1;
      else if (clr) m_to_err = 1'b0;
   endtask

   function automatic logic [2:0] m_grant();
      return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      logic [2:0] r_req;
      logic [2:0] r_done;
      logic       r_clr;
      logic [2:0] exp_owner;

      bus.req = 3'b000; bus.done = 3'b000; bus.err_clear = 1'b0;
      bus.dbg_ptr_we = 1'b0; bus.dbg_ptr_val = 3'b000;

      // Reset state
      repeat (2) step();
      check("rst_grant",  bus.grant, 3'b000);
      check("rst_gv",     {2'b0, bus.grant_valid}, 3'b000);
      check("rst_lw",     bus.last_winner, 3'b100);
      check("rst_oh_err", {2'b0, bus.oh_err}, 3'b000);
      check("rst_to_err", {2'b0, bus.timeout_err}, 3'b000);
      reset = 1'b0;

      // Vector table: {req, done, expected grant, expected last_winner}
      vecs[0]  = '{3'b001, 3'b000, 3'b001, 3'b001};
      vecs[1]  = '{3'b000, 3'b001, 3'b000, 3'b001};
      vecs[2]  = '{3'b111, 3'b000, 3'b010, 3'b010};
      vecs[3]  = '{3'b111, 3'b010, 3'b100, 3'b100};
      vecs[4]  = '{3'b111, 3'b100, 3'b001, 3'b001};
      vecs[5]  = '{3'b111, 3'b001, 3'b010, 3'b010};
      vecs[6]  = '{3'b101, 3'b100, 3'b010, 3'b010};
      vecs[7]  = '{3'b101, 3'b010, 3'b100, 3'b100};
      vecs[8]  = '{3'b100, 3'b100, 3'b100, 3'b100};
      vecs[9]  = '{3'b000, 3'b000, 3'b100, 3'b100};
      vecs[10] = '{3'b010, 3'b000, 3'b100, 3'b100};
      vecs[11] = '{3'b000, 3'b100, 3'b000, 3'b100};
      vecs[12] = '{3'b000, 3'b010, 3'b000, 3'b100};
      vecs[13] = '{3'b010, 3'b000, 3'b010, 3'b010};
      vecs[14] = '{3'b010, 3'b010, 3'b010, 3'b010};
      vecs[15] = '{3'b000, 3'b010, 3'b000, 3'b010};
      foreach (vecs[i]) begin
         bus.req  = vecs[i].req;
         bus.done = vecs[i].done;
         step();
         check($sformatf("vec%0d_grant", i), bus.grant, vecs[i].exp_grant);
         check($sformatf("vec%0d_gv", i), {2'b0, bus.grant_valid}, {2'b0, |vecs[i].exp_grant});
         check($sformatf("vec%0d_lw", i), bus.last_winner, vecs[i].exp_lw);
         check($sformatf("vec%0d_oh", i), {2'b0, bus.oh_err}, 3'b000);
      end
      bus.req = 3'b000; bus.done = 3'b000;

      // Long hold of owner 001 with 010 waiting; watchdog revokes only if built
      bus.req = 3'b011;
      step();
      check("hold_grant0", bus.grant, 3'b001);
      for (int k = 1; k < TMO; k++) begin
         step();
         check($sformatf("hold_grant%0d", k), bus.grant, 3'b001);
      end
      step();
      exp_owner = WD_EN ? 3'b010 : 3'b001;
      check("wd_grant",  bus.grant, exp_owner);
      check("wd_to_err", {2'b0, bus.timeout_err}, {2'b0, WD_EN});
      bus.req = 3'b000; bus.err_clear = 1'b1;
      step();
      bus.err_clear = 1'b0;
      check("wd_clr", {2'b0, bus.timeout_err}, 3'b000);
      bus.done = exp_owner;
      step();
      bus.done = 3'b000;
      check("wd_release", bus.grant, 3'b000);

      // Pointer fault via hook: sticky oh_err, set wins over clear
      bus.dbg_ptr_we = 1'b1; bus.dbg_ptr_val = 3'b011;
      step();
      bus.dbg_ptr_we = 1'b0;
      check("oh_ptr_forced", bus.last_winner, 3'b011);
      check("oh_not_yet",    {2'b0, bus.oh_err}, 3'b000);
      step();
      check("oh_set",        {2'b0, bus.oh_err}, 3'b001);
      bus.err_clear = 1'b1;
      step();
      bus.err_clear = 1'b0;
      check("oh_set_wins",   {2'b0, bus.oh_err}, 3'b001);
      bus.dbg_ptr_we = 1'b1; bus.dbg_ptr_val = 3'b100;
      step();
      bus.dbg_ptr_we = 1'b0;
      check("oh_ptr_fixed",  bus.last_winner, 3'b100);
      bus.err_clear = 1'b1;
      step();
      bus.err_clear = 1'b0;
      check("oh_cleared",    {2'b0, bus.oh_err}, 3'b000);

      // Fairness from pointer 100, then async reset while owner 100 holds
      bus.req = 3'b111;
      step();
      check("rr_first", bus.grant, 3'b001);
      bus.done = 3'b001;
      step();
      check("rr_second", bus.grant, 3'b010);
      bus.done = 3'b010;
      step();
      check("rr_third", bus.grant, 3'b100);
      bus.done = 3'b100;
      #2 reset = 1'b1;
      #1;
      check("arst_grant", bus.grant, 3'b000);
      check("arst_gv",    {2'b0, bus.grant_valid}, 3'b000);
      check("arst_lw",    bus.last_winner, 3'b100);
      #2 reset = 1'b0;
      bus.done = 3'b000;
      step();
      check("post_rst_grant", bus.grant, 3'b001);

      // Random traffic against the model
      bus.req = 3'b000;
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 400; c++) begin
         r_req = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       r_done = m_grant();
            1:       r_done = 3'($urandom_range(0, 7));
            default: r_done = 3'b000;
         endcase
         r_clr = ($urandom_range(0, 7) == 0);
         bus.req = r_req; bus.done = r_done; bus.err_clear = r_clr;
         model_cycle(r_req, r_done, r_clr);
         step();
         check($sformatf("rnd%0d_grant", c), bus.grant, m_grant());
         check($sformatf("rnd%0d_gv", c), {2'b0, bus.grant_valid}, {2'b0, m_owner >= 0});
         check($sformatf("rnd%0d_lw", c), bus.last_winner, 3'(1 << m_ptr));
         check($sformatf("rnd%0d_to", c), {2'b0, bus.timeout_err}, {2'b0, m_to_err});
         check($sformatf("rnd%0d_oh", c), {2'b0, bus.oh_err}, 3'b000);
      end
      bus.req = 3'b000; bus.done = 3'b000; bus.err_clear = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
